// File: rtl/servo_cmd_parser.sv
// servo_cmd_parser: turns a UART byte stream of "A<1-3 digits><CR|LF>"
// commands into a held 9-bit servo angle, with one-cycle done/error pulses
// and an inter-byte timeout that abandons a stalled command.
module servo_cmd_parser #(
  parameter int ANGLE_MAX   = 180,
  parameter int ANGLE_INIT  = 90,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [8:0] angle,
  output logic       sig_done,
  output logic       cmd_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DIGIT   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  // timer only ever needs to reach TIMEOUT_CYC-1
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [9:0]    ACC_MAX    = 10'(ANGLE_MAX);
  localparam logic [8:0]    ANGLE_RST  = 9'(ANGLE_INIT);

  logic [1:0]    state, state_n;
  logic [9:0]    acc, acc_n;
  logic [1:0]    ndig, ndig_n;
  logic [TW-1:0] timer;
  logic [8:0]    angle_n;
  logic          done_n, err_n;

  logic          is_a, is_digit, is_eol, timeout;
  logic [9:0]    acc_mac;

  // byte classification; ASCII digits carry their value in the low nibble
  always_comb begin
    is_a     = (rx_data == 8'h41) || (rx_data == 8'h61);
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    // acc*10 as shift-add; acc <= 99 here, so the result stays <= 999
    acc_mac  = (acc << 3) + (acc << 1) + {6'd0, rx_data[3:0]};
    timeout  = (state != ST_IDLE) && (timer == TIMER_LAST);
  end

  // next-state / datapath decode; a received byte always beats the timeout
  always_comb begin
    state_n = state;
    acc_n   = acc;
    ndig_n  = ndig;
    angle_n = angle;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (is_a) begin
            acc_n   = '0;
            ndig_n  = '0;
            state_n = ST_DIGIT;
          end
        end
        ST_DIGIT: begin
          if (is_digit) begin
            if (ndig == 2'd3) begin
              err_n   = 1'b1;
              state_n = ST_DISCARD;
            end else begin
              acc_n  = acc_mac;
              ndig_n = ndig + 2'd1;
            end
          end else if (is_a) begin
            // a fresh 'A' restarts the command without complaint
            acc_n  = '0;
            ndig_n = '0;
          end else if (is_eol) begin
            if ((ndig != 2'd0) && (acc <= ACC_MAX)) begin
              angle_n = acc[8:0];
              done_n  = 1'b1;
            end else begin
              err_n = 1'b1;
            end
            state_n = ST_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          // already reported; just wait for end of line
          if (is_eol) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (timeout) begin
      // a stalled command is an error; a stalled discard is not
      err_n   = (state == ST_DIGIT);
      state_n = ST_IDLE;
    end
  end

  // parser registers and registered output pulses
  always_ff @(posedge sclk) begin
    if (rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      ndig     <= '0;
      angle    <= ANGLE_RST;
      sig_done <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      ndig     <= ndig_n;
      angle    <= angle_n;
      sig_done <= done_n;
      cmd_err  <= err_n;
    end
  end

  // inter-byte timer: idle or any received byte restarts it
  always_ff @(posedge sclk) begin
    if (rst || rx_valid || (state == ST_IDLE)) timer <= '0;
    else                                       timer <= timer + 1'b1;
  end

endmodule

// File: tb/tb_servo_cmd_parser.sv
// Directed bench for servo_cmd_parser with hand-computed expectations.
module tb_servo_cmd_parser;

  localparam int TO = 100;

  logic       sclk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [8:0] angle;
  logic       sig_done;
  logic       cmd_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0, n_cerr = 0, n_both = 0;
  int d0, e0, k;
  bit hit;

  servo_cmd_parser #(.ANGLE_MAX(180), .ANGLE_INIT(90), .TIMEOUT_CYC(TO)) dut (
    .sclk(sclk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .angle(angle), .sig_done(sig_done), .cmd_err(cmd_err)
  );

  always #5 sclk = ~sclk;

  // pulse tallies, sampled mid-cycle
  always @(negedge sclk) begin
    if (sig_done) n_done++;
    if (cmd_err) n_cerr++;
    if (sig_done && cmd_err) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge sclk);
    rx_valid = 1'b0;
  endtask

  // returns on the negedge right after the last byte is sampled
  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      if (i != s.len() - 1) idle(gap);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    rst = 1'b0;
    chk("rst_angle", angle, 90);
    chk("rst_done", sig_done, 0);
    chk("rst_err", cmd_err, 0);
    idle(5);
    chk("quiet_angle", angle, 90);

    // spaced command
    d0 = n_done; e0 = n_cerr;
    send_str("A135\n", 1);
    chk("a135_angle", angle, 135);
    chk("a135_done", sig_done, 1);
    chk("a135_err", cmd_err, 0);
    idle(1);
    chk("a135_done_1cyc", sig_done, 0);
    idle(2);
    chk("a135_ndone", n_done - d0, 1);

    // back-to-back, both terminators, both 'A' cases, bounds 0 and 180
    d0 = n_done;
    send_str("A0\r", 0);
    chk("a0_angle", angle, 0);
    chk("a0_done", sig_done, 1);
    send_str("a180\n", 0);
    chk("a180_angle", angle, 180);
    idle(2);
    chk("a0_a180_ndone", n_done - d0, 2);

    // out of range and too many digits
    do_reset();
    d0 = n_done; e0 = n_cerr;
    send_str("A181\n", 0);
    chk("a181_err", cmd_err, 1);
    chk("a181_angle", angle, 90);
    send_str("A123", 0);
    chk("a123_noerr", cmd_err, 0);
    send_byte("4");
    chk("4th_digit_err", cmd_err, 1);
    send_byte(8'h0A);
    chk("discard_eol_err", cmd_err, 0);
    chk("discard_eol_done", sig_done, 0);
    chk("a1234_angle", angle, 90);
    idle(2);
    chk("rej_nerr", n_cerr - e0, 2);
    chk("rej_ndone", n_done - d0, 0);

    // bad character then recovery
    e0 = n_cerr;
    send_str("A4x", 0);
    chk("x_err", cmd_err, 1);
    send_str("9\n", 0);
    chk("x_tail_angle", angle, 90);
    send_str("A45\n", 0);
    chk("a45_angle", angle, 45);
    idle(2);
    chk("x_nerr", n_cerr - e0, 1);

    // empty command and restart inside a command
    send_str("A\n", 0);
    chk("empty_err", cmd_err, 1);
    chk("empty_angle", angle, 45);
    send_str("A9A7\n", 0);
    chk("restart_angle", angle, 7);
    chk("restart_done", sig_done, 1);
    send_str("A45\n", 0);

    // inter-byte timeout: error exactly TO cycles after the last byte
    idle(2);
    d0 = n_done; e0 = n_cerr;
    send_str("A12", 0);
    k = 0; hit = 0;
    while (k < 3 * TO && !hit) begin
      @(negedge sclk);
      k++;
      if (cmd_err) hit = 1;
    end
    chk("to_latency", k, TO);
    idle(2);
    send_str("3\n", 0);
    chk("to_tail_done", sig_done, 0);
    chk("to_tail_err", cmd_err, 0);
    chk("to_tail_angle", angle, 45);
    idle(2);
    chk("to_nerr", n_cerr - e0, 1);
    chk("to_ndone", n_done - d0, 0);

    // reset mid-command
    send_str("A1", 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst_angle", angle, 90);
    send_str("7\n", 0);
    chk("midrst_tail_angle", angle, 90);
    chk("midrst_tail_err", cmd_err, 0);

    // reset beats a simultaneous terminator
    send_str("A5", 0);
    rst = 1'b1; rx_data = 8'h0A; rx_valid = 1'b1;
    @(negedge sclk);
    rx_valid = 1'b0; rst = 1'b0;
    chk("rstwin_angle", angle, 90);
    chk("rstwin_done", sig_done, 0);
    send_str("A60\n", 0);
    chk("a60_angle", angle, 60);
    idle(2);
    chk("never_both", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
